// File: rtl/heard_packer.sv
// heard_packer: packs 4-bit items sharing a method tag into words of NIBBLES
// nibbles, with a one-word output slot and a ready/enable handshake on both
// sides. A change of method tag flushes the partial word early.
// Optional feature: define HEARD_PACK_TIMEOUT_EN to flush a partial word after
// TIMEOUT idle cycles; without it a partial word waits for a tag change.
module heard_packer #(
  parameter int NIBBLES = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 heard__ENA,
  input  logic [5:0]           heard_meth,
  input  logic [3:0]           heard_v,
  output logic                 heard__RDY,
  output logic                 word_put__ENA,
  output logic [4*NIBBLES-1:0] word_put_data,
  output logic [5:0]           word_put_meth,
  output logic [3:0]           word_put_count,
  input  logic                 word_put__RDY
);

  localparam int         DW   = 4 * NIBBLES;
  localparam logic [3:0] FULL = 4'(NIBBLES);

  if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_nibbles
    $error("heard_packer: NIBBLES must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("heard_packer: TIMEOUT must be in 1..255");
  end

  logic [DW-1:0] acc_data_q, acc_data_d;
  logic [5:0]    acc_meth_q, acc_meth_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          slot_vld_q, slot_vld_d;
  logic [DW-1:0] slot_data_q, slot_data_d;
  logic [5:0]    slot_meth_q, slot_meth_d;
  logic [3:0]    slot_cnt_q, slot_cnt_d;

  logic          drain;
  logic          accept;
  logic          flush_to;
  logic [DW-1:0] acc_ins;
  logic [DW-1:0] nib_new;

  // The slot is free for a new word when empty or when it drains this cycle.
  assign drain          = slot_vld_q && word_put__RDY;
  assign heard__RDY     = !slot_vld_q || word_put__RDY;
  assign accept         = heard__ENA && heard__RDY;
  assign word_put__ENA  = drain;
  assign word_put_data  = slot_data_q;
  assign word_put_meth  = slot_meth_q;
  assign word_put_count = slot_cnt_q;
  assign nib_new        = {{(DW-4){1'b0}}, heard_v};

`ifdef HEARD_PACK_TIMEOUT_EN
  localparam logic [7:0] TO = 8'(TIMEOUT);
  logic [7:0] idle_q, idle_d;

  // An accept always wins over a pending timeout flush.
  assign flush_to = !accept && (cnt_q != 4'd0) && (idle_q == TO) && heard__RDY;

  // Idle counter: cleared by accepts and flushes, counts while a partial word waits.
  always_comb begin
    idle_d = idle_q;
    if (accept || flush_to) begin
      idle_d = 8'd0;
    end else if (cnt_q != 4'd0 && idle_q != TO) begin
      idle_d = idle_q + 8'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idle_q <= 8'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign flush_to = 1'b0;
`endif

  // Accumulator with the incoming nibble written at position cnt.
  always_comb begin
    acc_ins = acc_data_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_q == 4'(i)) begin
        acc_ins[4*i +: 4] = heard_v;
      end
    end
  end

  // Next state of accumulator and output slot.
  always_comb begin
    acc_data_d  = acc_data_q;
    acc_meth_d  = acc_meth_q;
    cnt_d       = cnt_q;
    slot_vld_d  = slot_vld_q;
    slot_data_d = slot_data_q;
    slot_meth_d = slot_meth_q;
    slot_cnt_d  = slot_cnt_q;
    if (drain) begin
      slot_vld_d = 1'b0;
    end
    if (accept) begin
      if (cnt_q == 4'd0) begin
        acc_meth_d = heard_meth;
        acc_data_d = nib_new;
        cnt_d      = 4'd1;
      end else if (heard_meth == acc_meth_q) begin
        if (cnt_q + 4'd1 == FULL) begin
          slot_vld_d  = 1'b1;
          slot_data_d = acc_ins;
          slot_meth_d = acc_meth_q;
          slot_cnt_d  = FULL;
          acc_data_d  = '0;
          cnt_d       = 4'd0;
        end else begin
          acc_data_d = acc_ins;
          cnt_d      = cnt_q + 4'd1;
        end
      end else begin
        slot_vld_d  = 1'b1;
        slot_data_d = acc_data_q;
        slot_meth_d = acc_meth_q;
        slot_cnt_d  = cnt_q;
        acc_meth_d  = heard_meth;
        acc_data_d  = nib_new;
        cnt_d       = 4'd1;
      end
    end else if (flush_to) begin
      slot_vld_d  = 1'b1;
      slot_data_d = acc_data_q;
      slot_meth_d = acc_meth_q;
      slot_cnt_d  = cnt_q;
      acc_data_d  = '0;
      cnt_d       = 4'd0;
    end
  end

  // State registers; reset discards any partial or pending word.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_data_q  <= '0;
      acc_meth_q  <= 6'd0;
      cnt_q       <= 4'd0;
      slot_vld_q  <= 1'b0;
      slot_data_q <= '0;
      slot_meth_q <= 6'd0;
      slot_cnt_q  <= 4'd0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_meth_q  <= acc_meth_d;
      cnt_q       <= cnt_d;
      slot_vld_q  <= slot_vld_d;
      slot_data_q <= slot_data_d;
      slot_meth_q <= slot_meth_d;
      slot_cnt_q  <= slot_cnt_d;
    end
  end

endmodule

// File: tb/tb_heard_packer.sv
// Bench for heard_packer: directed scenarios plus a randomized stream checked
// against a sequence-level model of the nibble stream.
module tb_heard_packer;

  localparam int NIB = 4;
  localparam int TO  = 16;

  typedef struct packed {
    logic [4*NIB-1:0] data;
    logic [5:0]       meth;
    logic [3:0]       cnt;
  } word_t;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             heard_ena = 1'b0;
  logic [5:0]       heard_meth = 6'd0;
  logic [3:0]       heard_v = 4'd0;
  logic             heard_rdy;
  logic             put_ena;
  logic [4*NIB-1:0] put_data;
  logic [5:0]       put_meth;
  logic [3:0]       put_cnt;
  logic             put_rdy = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  bit obs_rdy;
  bit last_acc;
  word_t      out_q[$];
  logic [9:0] in_q[$];

  heard_packer #(.NIBBLES(NIB), .TIMEOUT(TO)) dut (
    .CLK            (clk),
    .nRST           (nrst),
    .heard__ENA     (heard_ena),
    .heard_meth     (heard_meth),
    .heard_v        (heard_v),
    .heard__RDY     (heard_rdy),
    .word_put__ENA  (put_ena),
    .word_put_data  (put_data),
    .word_put_meth  (put_meth),
    .word_put_count (put_cnt),
    .word_put__RDY  (put_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: set downstream ready, sample outputs, offer an item if ready.
  task automatic step(input bit ena, input logic [5:0] m, input logic [3:0] v, input bit prdy);
    @(negedge clk);
    put_rdy = prdy;
    #1;
    obs_rdy = heard_rdy;
    if (put_ena) out_q.push_back({put_data, put_meth, put_cnt});
    last_acc   = ena && heard_rdy;
    heard_ena  = last_acc;
    heard_meth = m;
    heard_v    = v;
    if (last_acc) in_q.push_back({m, v});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0, 4'd0, 1'b1);
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [15:0] d,
                          input logic [5:0] m, input logic [3:0] c);
    if (out_q.size() > idx) begin
      check({tag, "_data"}, 32'(out_q[idx].data), 32'(d));
      check({tag, "_meth"}, 32'(out_q[idx].meth), 32'(m));
      check({tag, "_cnt"},  32'(out_q[idx].cnt),  32'(c));
    end else begin
      check({tag, "_present"}, 32'(out_q.size()), 32'(idx + 1));
    end
  endtask

  // Mid-cycle reset pulse, checking outputs while reset is held.
  task automatic pulse_rst(input string tag);
    @(negedge clk);
    heard_ena = 1'b0;
    #1 nrst = 1'b0;
    put_rdy = 1'b1;
    #1;
    check({tag, "_ena"}, 32'(put_ena), 32'd0);
    check({tag, "_rdy"}, 32'(heard_rdy), 32'd1);
    #1 nrst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int pos;
    bit done;
    logic [9:0] strm[$];

    // Reset state
    #2;
    check("rst_ena", 32'(put_ena), 32'd0);
    check("rst_rdy", 32'(heard_rdy), 32'd1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // Four items of one tag form one full word, one cycle after the last accept
    out_q.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, 6'd5, 4'(i), 1'b1);
    check("full_early", 32'(out_q.size()), 32'd0);
    idle(1);
    check("full_n", 32'(out_q.size()), 32'd1);
    chk_word("full", 0, 16'h4321, 6'd5, 4'd4);

    // Tag change flushes a partial word; new tag starts the accumulator
    out_q.delete();
    step(1'b1, 6'd5, 4'hA, 1'b1);
    step(1'b1, 6'd5, 4'hB, 1'b1);
    step(1'b1, 6'd9, 4'hC, 1'b1);
    idle(1);
    check("split_n", 32'(out_q.size()), 32'd1);
    chk_word("split", 0, 16'h00BA, 6'd5, 4'd2);
    step(1'b1, 6'd9, 4'hD, 1'b1);
    step(1'b1, 6'd9, 4'hE, 1'b1);
    step(1'b1, 6'd9, 4'hF, 1'b1);
    idle(1);
    check("split2_n", 32'(out_q.size()), 32'd2);
    chk_word("split2", 1, 16'hFEDC, 6'd9, 4'd4);

    // Backpressure: full slot blocks input; release drains and accepts together
    out_q.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, 6'd1, 4'(i), 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'd2, 4'd5, 1'b0);
      check("bp_rdy_low", 32'(obs_rdy), 32'd0);
    end
    check("bp_held", 32'(out_q.size()), 32'd0);
    step(1'b1, 6'd2, 4'd5, 1'b1);
    check("bp_rdy_high", 32'(obs_rdy), 32'd1);
    check("bp_emit", 32'(out_q.size()), 32'd1);
    step(1'b1, 6'd2, 4'd6, 1'b1);
    step(1'b1, 6'd2, 4'd7, 1'b1);
    step(1'b1, 6'd2, 4'd8, 1'b1);
    idle(1);
    check("bp_n", 32'(out_q.size()), 32'd2);
    chk_word("bp0", 0, 16'h4321, 6'd1, 4'd4);
    chk_word("bp1", 1, 16'h8765, 6'd2, 4'd4);

    // Single item followed by idle cycles
    out_q.delete();
    first = 0;
    step(1'b1, 6'd3, 4'd7, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 6'd0, 4'd0, 1'b1);
      if (first == 0 && out_q.size() > 0) first = i;
    end
`ifdef HEARD_PACK_TIMEOUT_EN
    check("to_n", 32'(out_q.size()), 32'd1);
    check("to_not_early", 32'(first > TO), 32'd1);
    check("to_on_time", 32'(first <= TO + 2), 32'd1);
    chk_word("to", 0, 16'h0007, 6'd3, 4'd1);
`else
    check("noto_n", 32'(out_q.size()), 32'd0);
    step(1'b1, 6'd4, 4'd1, 1'b1);
    idle(1);
    check("noto_flush_n", 32'(out_q.size()), 32'd1);
    chk_word("noto", 0, 16'h0007, 6'd3, 4'd1);
`endif

    // Reset with a 3-nibble partial word discards it
    pulse_rst("rst_cnt3");
    out_q.delete();
    for (int i = 1; i <= 3; i++) step(1'b1, 6'd6, 4'(i), 1'b1);
    pulse_rst("rst_mid");
    idle(2);
    for (int i = 5; i <= 8; i++) step(1'b1, 6'd6, 4'(i), 1'b1);
    idle(1);
    check("rst_cnt3_n", 32'(out_q.size()), 32'd1);
    chk_word("rst_cnt3", 0, 16'h8765, 6'd6, 4'd4);

    // Reset with a pending blocked slot and a live accumulator
    out_q.delete();
    for (int i = 1; i <= 3; i++) step(1'b1, 6'd6, 4'(i), 1'b1);
    step(1'b1, 6'd7, 4'd1, 1'b0);
    step(1'b0, 6'd0, 4'd0, 1'b0);
    check("rst_slot_blocked", 32'(obs_rdy), 32'd0);
    pulse_rst("rst_slot");
    idle(3);
    check("rst_slot_drop", 32'(out_q.size()), 32'd0);
    for (int i = 1; i <= 4; i++) step(1'b1, 6'd8, 4'(i), 1'b1);
    idle(1);
    check("rst_slot_n", 32'(out_q.size()), 32'd1);
    chk_word("rst_slot", 0, 16'h4321, 6'd8, 4'd4);

    // Random stream with random downstream backpressure
    pulse_rst("rnd_rst");
    out_q.delete();
    in_q.delete();
    for (int k = 0; k < 3000 && in_q.size() < 200; k++)
      step($urandom_range(0, 3) != 0, 6'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 4) > 1);
    check("rnd_items", 32'(in_q.size()), 32'd200);
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      step(1'b1, 6'd63, 4'd5, 1'b1);
      done = last_acc;
    end
    check("rnd_term_acc", 32'(done), 32'd1);
    idle(40);
    pos = 0;
    foreach (out_q[w]) begin
      check("rnd_cnt_range", 32'(out_q[w].cnt >= 1 && out_q[w].cnt <= NIB), 32'd1);
      check("rnd_pad_zero", 32'(out_q[w].data >> (4 * out_q[w].cnt)), 32'd0);
      for (int j = 0; j < out_q[w].cnt && j < NIB; j++)
        strm.push_back({out_q[w].meth, out_q[w].data[4*j +: 4]});
      pos += int'(out_q[w].cnt);
`ifndef HEARD_PACK_TIMEOUT_EN
      if (out_q[w].cnt < NIB && pos < in_q.size())
        check("rnd_split_tag", 32'(in_q[pos][9:4] != out_q[w].meth), 32'd1);
`endif
    end
`ifdef HEARD_PACK_TIMEOUT_EN
    check("rnd_len", 32'(strm.size()), 32'(in_q.size()));
`else
    check("rnd_len", 32'(strm.size()), 32'(in_q.size() - 1));
`endif
    foreach (strm[i]) begin
      if (i < in_q.size()) check("rnd_nibble", 32'(strm[i]), 32'(in_q[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/heard_packer.md
HEARD_PACKER -- requirements
Module: heard_packer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4: nibbles packed per output word, legal range 2..8.
REQ-002 The block SHALL have parameter TIMEOUT, default 16: idle cycles before a partial word is flushed, legal range 1..255.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port heard__ENA, input, 1: upstream transfer strobe, asserted only while heard__RDY=1.
REQ-006 The block SHALL have port heard$meth, input, 6: method tag of the incoming item.
REQ-007 The block SHALL have port heard$v, input, 4: data nibble of the incoming item.
REQ-008 The block SHALL have port heard__RDY, output, 1: the block can accept an item this cycle.
REQ-009 The block SHALL have port word$put__ENA, output, 1: packed word transfer strobe.
REQ-010 The block SHALL have port word$put$data, output, 4*NIBBLES: packed nibbles, nibble 0 in bits [3:0].
REQ-011 The block SHALL have port word$put$meth, output, 6: method tag shared by all nibbles in the word.
REQ-012 The block SHALL have port word$put$count, output, 4: number of valid nibbles, 1..NIBBLES.
REQ-013 The block SHALL have port word$put__RDY, input, 1: downstream can take a word this cycle.

Function
REQ-014 The block SHALL hold an accumulator (data, meth, cnt) and one output slot (valid, data, meth, count).
REQ-015 An item SHALL be accepted in a cycle where heard__ENA=1; heard__RDY SHALL be !slot.valid || word$put__RDY.
REQ-016 word$put__ENA SHALL be slot.valid && word$put__RDY; the slot SHALL clear on that cycle unless it is refilled in the same cycle.
REQ-017 On accept with cnt=0: acc.meth<=heard$meth, nibble 0<=heard$v, cnt<=1.
REQ-018 On accept with cnt>0 and heard$meth==acc.meth: nibble[cnt]<=heard$v and cnt<=cnt+1.
REQ-019 When that insert makes cnt reach NIBBLES, the completed word SHALL move to the slot in the same edge, and cnt SHALL become 0.
REQ-020 On accept with cnt>0 and a differing heard$meth, the partial accumulator SHALL move to the slot, and the incoming item SHALL start a new accumulator as in REQ-017.
REQ-021 Unfilled nibbles in word$put$data SHALL be zero.
REQ-022 Latency from the accept that completes a word to word$put__ENA SHALL be 1 cycle, given word$put__RDY=1.
REQ-023 Back-to-back accepts SHALL sustain 1 item per cycle while the downstream is ready.

Reset
REQ-024 While nRST=0, every register SHALL clear asynchronously: cnt=0, slot.valid=0, idle counter=0, data=0, meth=0.
REQ-025 During and after reset, word$put__ENA SHALL be 0 and heard__RDY SHALL be 1.
REQ-026 Reset mid-word SHALL discard the accumulator and the slot contents without emitting them.

Configuration
REQ-027 With HEARD_PACK_TIMEOUT_EN defined, an 8-bit idle counter SHALL reset on every accept and increment while cnt>0, saturating at TIMEOUT.
REQ-028 With HEARD_PACK_TIMEOUT_EN defined, when the counter equals TIMEOUT and the slot is free (or draining this cycle), the partial word SHALL move to the slot, and cnt and the counter SHALL return to 0.
REQ-029 With HEARD_PACK_TIMEOUT_EN defined, an accept and a timeout in the same cycle SHALL be resolved in favour of the accept; the counter resets and no timeout flush occurs.
REQ-030 Without HEARD_PACK_TIMEOUT_EN, no idle counter SHALL exist, and a partial word SHALL leave only via REQ-020.

Verification
REQ-031 The bench SHALL cover: NIBBLES=4, four items meth=5 with v=1,2,3,4, RDY=1 -> one word: data=0x4321, meth=5, count=4, one cycle after the 4th accept.
REQ-032 The bench SHALL cover: items (meth 5, v=A), (meth 5, v=B), (meth 9, v=C) -> word data=0x00BA, meth=5, count=2, with the accumulator holding meth 9, cnt 1.
REQ-033 The bench SHALL cover: slot full with word$put__RDY=0 -> heard__RDY=0 and no state change; raising RDY -> word emitted, and an accept in that same cycle is honoured.
REQ-034 The bench SHALL cover (HEARD_PACK_TIMEOUT_EN, TIMEOUT=16): one item meth=3, v=7, then idle -> word data=0x0007, count=1, emitted after 16 idle cycles; without the macro, no word is emitted.
REQ-035 The bench SHALL cover: nRST pulsed low while cnt=3 and slot.valid=1 -> both cleared immediately, no word emitted, heard__RDY=1.
REQ-036 The bench SHALL cover: 200 random items with random word$put__RDY -> concatenated output nibbles per meth run match the input sequence exactly, with no loss or duplication.
